pcs_tx_sequencer: RTL and testbench

Transmit-side sequencer for the 10GBASE-R PCS. It brings the TX path out of reset once the transceiver reports ready and enables the self-synchronising scrambler. It then drives the 64b/66b gearbox sequence counter and generates the periodic pause that stalls the scrambler and the MAC for one block-time every 32 blocks. It sits between the MAC TX interface, the 64b/66b encoder, the scrambler and the TX gearbox.

---
 rtl/pcs_tx_sequencer.sv | 124 ++++++++++++
 tb/tb_pcs_tx_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pcs_tx_sequencer.sv
// pcs_tx_sequencer: 10GBASE-R PCS TX bring-up, 64b/66b gearbox sequence and scrambler pause.
// The forced-idle INIT_IDLE phase is built only when PCS_TX_INIT_IDLE_EN is defined.
module pcs_tx_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int INIT_IDLE_BLOCKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gt_tx_ready,
  input  logic        mac_tx_valid,
  output logic        scr_init_done,
  output logic        scr_pause,
  output logic [6:0]  gb_seq,
  output logic        half_sel,
  output logic        hdr_valid,
  output logic        force_idle,
  output logic        mac_tx_ready,
  output logic [15:0] idle_ins_cnt
);

  localparam int         CPB         = 64 / DATA_WIDTH;
  localparam int         SEQ_LEN     = 33 * CPB;
  localparam logic [6:0] SEQ_LAST    = 7'(SEQ_LEN - 1);
  localparam logic [6:0] PAUSE_START = 7'(32 * CPB);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_INIT_IDLE,
    ST_RUN
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] seq_inc, seq_nxt;
  logic       pause_nxt, half_nxt, active_nxt;

`ifdef PCS_TX_INIT_IDLE_EN
  logic [7:0] blk_cnt;
  logic [8:0] blk_started;
  logic       init_finish;

  // Blocks started so far, including one whose header cycle is this cycle.
  assign blk_started = {1'b0, blk_cnt} + 9'(hdr_valid);
  assign init_finish = (blk_started >= 9'(INIT_IDLE_BLOCKS)) &&
                       (seq_inc < PAUSE_START) &&
                       ((CPB == 1) || !seq_inc[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
    end else if (state != ST_INIT_IDLE) begin
      blk_cnt <= '0;
    end else if (hdr_valid && (blk_cnt != 8'hFF)) begin
      blk_cnt <= blk_cnt + 8'd1;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    seq_inc   = (gb_seq == SEQ_LAST) ? 7'd0 : gb_seq + 7'd1;
    case (state)
      ST_WAIT: begin
        if (gt_tx_ready) begin
`ifdef PCS_TX_INIT_IDLE_EN
          state_nxt = ST_INIT_IDLE;
`else
          state_nxt = ST_RUN;
`endif
        end
      end
`ifdef PCS_TX_INIT_IDLE_EN
      ST_INIT_IDLE: begin
        if (!gt_tx_ready)     state_nxt = ST_WAIT;
        else if (init_finish) state_nxt = ST_RUN;
      end
`endif
      ST_RUN: begin
        if (!gt_tx_ready) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase

    // The counter holds 0 in WAIT and shows 0 on the first active cycle.
    seq_nxt    = ((state == ST_WAIT) || (state_nxt == ST_WAIT)) ? 7'd0 : seq_inc;
    pause_nxt  = (seq_nxt >= PAUSE_START);
    half_nxt   = (CPB == 2) ? seq_nxt[0] : 1'b0;
    active_nxt = (state_nxt != ST_WAIT);
  end

  // Outputs are registered from next-cycle values so they all describe the shown gb_seq.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_WAIT;
      gb_seq        <= '0;
      scr_init_done <= 1'b0;
      scr_pause     <= 1'b0;
      half_sel      <= 1'b0;
      hdr_valid     <= 1'b0;
      force_idle    <= 1'b1;
      mac_tx_ready  <= 1'b0;
    end else begin
      state         <= state_nxt;
      gb_seq        <= seq_nxt;
      scr_init_done <= active_nxt;
      scr_pause     <= active_nxt && pause_nxt;
      half_sel      <= half_nxt;
      hdr_valid     <= active_nxt && !half_nxt && !pause_nxt;
      force_idle    <= (state_nxt != ST_RUN);
      mac_tx_ready  <= (state_nxt == ST_RUN) && !pause_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_ins_cnt <= '0;
    end else if ((state == ST_RUN) && mac_tx_ready && !mac_tx_valid &&
                 (idle_ins_cnt != 16'hFFFF)) begin
      idle_ins_cnt <= idle_ins_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Directed bench for pcs_tx_sequencer: a 64-bit and a 32-bit instance on one clock.
// Expectations follow PCS_TX_INIT_IDLE_EN as seen by this compile.
module tb_pcs_tx_sequencer;

`ifdef PCS_TX_INIT_IDLE_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;

  logic        gt64, valid64, init64, pause64, half64, hdr64, fidle64, ready64;
  logic [6:0]  seq64;
  logic [15:0] cnt64;
  logic        gt32, valid32, init32, pause32, half32, hdr32, fidle32, ready32;
  logic [6:0]  seq32;
  logic [15:0] cnt32;

  int n_checks = 0;
  int n_fail   = 0;

  pcs_tx_sequencer #(.DATA_WIDTH(64), .INIT_IDLE_BLOCKS(16)) u_dut64 (
    .clk(clk), .reset(reset), .gt_tx_ready(gt64), .mac_tx_valid(valid64),
    .scr_init_done(init64), .scr_pause(pause64), .gb_seq(seq64), .half_sel(half64),
    .hdr_valid(hdr64), .force_idle(fidle64), .mac_tx_ready(ready64), .idle_ins_cnt(cnt64)
  );

  pcs_tx_sequencer #(.DATA_WIDTH(32), .INIT_IDLE_BLOCKS(32)) u_dut32 (
    .clk(clk), .reset(reset), .gt_tx_ready(gt32), .mac_tx_valid(valid32),
    .scr_init_done(init32), .scr_pause(pause32), .gb_seq(seq32), .half_sel(half32),
    .hdr_valid(hdr32), .force_idle(fidle32), .mac_tx_ready(ready32), .idle_ins_cnt(cnt32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Runs dut64 from its first active cycle to its first mac_tx_ready cycle.
  task automatic bringup64(input string tag);
    int n = 0;
    int idle_blocks = 0;
    while (!ready64 && n < 200) begin
      if (hdr64 && fidle64) idle_blocks++;
      n++;
      step();
    end
    check({tag, "_cycles"}, n, INIT_EN ? 16 : 0);
    check({tag, "_idle_blocks"}, idle_blocks, INIT_EN ? 16 : 0);
    check({tag, "_seq"}, seq64, INIT_EN ? 16 : 0);
    check({tag, "_force_idle"}, fidle64, 0);
  endtask

  initial begin
    int n, xfers, pauses, seq_err, cnt_before;
    logic [6:0] prev;
    logic [10:0] exp_vec;
    logic p;

    reset = 1'b1; gt64 = 1'b0; valid64 = 1'b1; gt32 = 1'b0; valid32 = 1'b1;
    step(); step();
    check("rst64_outs", {init64, pause64, seq64, half64, hdr64, fidle64, ready64, cnt64},
          {1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
    check("rst32_outs", {init32, pause32, seq32, half32, hdr32, fidle32, ready32, cnt32},
          {1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
    reset = 1'b0;
    step(); step();
    check("wait64_hold", {init64, seq64, fidle64, ready64}, {1'b0, 7'd0, 1'b1, 1'b0});

    // Bring-up of the 64-bit instance: one cycle to scr_init_done.
    gt64 = 1'b1;
    step();
    check("up64_init_done", init64, 1);
    check("up64_first_seq", {seq64, hdr64}, {7'd0, 1'b1});
    bringup64("up64");

    // 330 RUN cycles: 10 whole sequences of 33.
    xfers = 0; pauses = 0; seq_err = 0; prev = seq64;
    for (int i = 0; i < 330; i++) begin
      if (ready64 && valid64) xfers++;
      if (pause64) pauses++;
      step();
      if (seq64 != ((prev == 7'd32) ? 7'd0 : prev + 7'd1)) seq_err++;
      prev = seq64;
    end
    check("run64_transfers", xfers, 320);
    check("run64_pauses", pauses, 10);
    check("run64_seq_wrap_errors", seq_err, 0);

    // gt_tx_ready dropped for one cycle at gb_seq=10, with an underrun on that cycle.
    n = 0;
    while (seq64 != 7'd10 && n < 40) begin n++; step(); end
    check("drop64_reach_seq10", seq64, 10);
    cnt_before = cnt64;
    check("drop64_cnt_before", cnt_before, 0);
    gt64 = 1'b0; valid64 = 1'b0;
    step();
    check("drop64_wait", {init64, seq64, ready64, fidle64, pause64}, {1'b0, 7'd0, 1'b0, 1'b1, 1'b0});
    check("drop64_underrun_counted", cnt64, 1);
    gt64 = 1'b1; valid64 = 1'b1;
    step();
    check("reup64_init_done", {init64, seq64}, {1'b1, 7'd0});
    bringup64("reup64");

    // 32-bit instance: INIT_IDLE of 32 blocks ends at the pause window, so RUN starts at 0.
    gt32 = 1'b1;
    step();
    check("up32_init_done", init32, 1);
    n = 0;
    while (!ready32 && n < 200) begin n++; step(); end
    check("up32_cycles", n, INIT_EN ? 66 : 0);
    check("up32_first_run", {seq32, half32, fidle32}, {7'd0, 1'b0, 1'b0});
    for (int i = 0; i < 66; i++) begin
      p = (i >= 64);
      exp_vec = {7'(i), 1'(i % 2), (i % 2 == 0) && !p, p, !p};
      check($sformatf("seq32_at_%0d", i), {seq32, half32, hdr32, pause32, ready32}, exp_vec);
      step();
    end
    check("seq32_wrap", {seq32, half32, hdr32}, {7'd0, 1'b0, 1'b1});

    // Underrun saturation on the 64-bit instance, then asynchronous clear.
    valid64 = 1'b0;
    n = 0;
    while (cnt64 != 16'hFFFF && n < 70000) begin n++; step(); end
    check("sat64_reached", cnt64, 16'hFFFF);
    for (int i = 0; i < 40; i++) step();
    check("sat64_held", cnt64, 16'hFFFF);
    reset = 1'b1;
    #1;
    check("async_rst64", {cnt64, init64, seq64, ready64, hdr64}, {16'd0, 1'b0, 7'd0, 1'b0, 1'b0});
    step();
    reset = 1'b0;
    step();
    check("post_rst64_first_block", {init64, seq64, half64, hdr64}, {1'b1, 7'd0, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
